// File: rtl/echo_request_input.sv
// echo_request_input
//   Receive-side endpoint of the Echo request pipe. Words {v, meth, tag}
//   arriving from the transport are buffered in a DEPTH-entry FIFO. A head
//   word with tag 1 is replayed as a say(meth, v) invocation once the
//   handler is ready. A head word with any other tag is dropped in one
//   cycle and counted in a saturating error counter.
//
// Optional feature macro: ECHO_REQUEST_INPUT_BYPASS_EN
//   When defined, a word arriving while the FIFO is empty skips storage.
//   A tag 1 word with the handler ready is presented as say in the same
//   cycle. A bad-tag word is counted directly.
//
// Ports
//   CLK               in   clock, all state on posedge
//   nRST              in   asynchronous active-low reset
//   pipe_enq_ena      in   enqueue strobe from the transport
//   pipe_enq_v        in   96-bit word {v[95:64], meth[63:32], tag[31:0]}
//   pipe_enq_rdy      out  FIFO can accept a word (state only)
//   request_say_ena   out  say invocation strobe
//   request_say_meth  out  meth argument
//   request_say_v     out  v argument
//   request_say_rdy   in   handler can accept say
//   count             out  current FIFO occupancy
//   err_count         out  discarded words, saturating at all-ones

module echo_request_input #(
   parameter int DEPTH = 4,
   parameter int ERR_W = 16
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic                     pipe_enq_ena,
   input  logic [95:0]              pipe_enq_v,
   output logic                     pipe_enq_rdy,
   output logic                     request_say_ena,
   output logic [31:0]              request_say_meth,
   output logic [31:0]              request_say_v,
   input  logic                     request_say_rdy,
   output logic [$clog2(DEPTH):0]   count,
   output logic [ERR_W-1:0]         err_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [95:0]      fifo_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             ready_q, ready_d;

   logic [95:0] head_word;
   logic [31:0] head_tag;
   logic [31:0] in_tag;
   logic        not_empty;
   logic        enq_rdy;
   logic        enq_fire;
   logic        say_fire;
   logic        head_drop;
   logic        pop;
   logic        byp_say;
   logic        byp_drop;
   logic        wr_en;
   logic        err_inc;

   always_comb begin
      head_word = fifo_q[rd_ptr_q];
      head_tag  = head_word[31:0];
      in_tag    = pipe_enq_v[31:0];
      not_empty = (count_q != '0);
      // Ready is a function of state only so the transport never sees a
      // combinational path from its own strobe.
      enq_rdy   = ready_q & (count_q != FULL);
      enq_fire  = pipe_enq_ena & enq_rdy;

      say_fire  = not_empty & (head_tag == 32'd1) & request_say_rdy;
      // Bad-tag heads leave regardless of handler readiness.
      head_drop = not_empty & (head_tag != 32'd1);
      pop       = say_fire | head_drop;

`ifdef ECHO_REQUEST_INPUT_BYPASS_EN
      byp_say  = ~not_empty & enq_fire & (in_tag == 32'd1) & request_say_rdy;
      byp_drop = ~not_empty & enq_fire & (in_tag != 32'd1);
      request_say_meth = not_empty ? head_word[63:32] : pipe_enq_v[63:32];
      request_say_v    = not_empty ? head_word[95:64] : pipe_enq_v[95:64];
`else
      byp_say  = 1'b0;
      byp_drop = 1'b0;
      request_say_meth = head_word[63:32];
      request_say_v    = head_word[95:64];
`endif

      wr_en   = enq_fire & ~byp_say & ~byp_drop;
      err_inc = head_drop | byp_drop;

      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      err_d    = (err_inc && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
      ready_d  = 1'b1;

      pipe_enq_rdy    = enq_rdy;
      request_say_ena = say_fire | byp_say;
      count           = count_q;
      err_count       = err_q;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= '0;
         ready_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge CLK) begin
      if (wr_en) fifo_q[wr_ptr_q] <= pipe_enq_v;
   end

endmodule

// File: tb/tb_echo_request_input.sv
// tb_echo_request_input
//   Queue-based reference model plus scoreboard for echo_request_input.
//   The DUT is built with ERR_W=2 so error-counter saturation is reachable.
//   Follows ECHO_REQUEST_INPUT_BYPASS_EN if defined for the build.

module tb_echo_request_input;

   localparam int DEPTH = 4;
   localparam int ERR_W = 2;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        enq_ena;
   logic [95:0] enq_word;
   logic        say_rdy;
   logic        enq_rdy;
   logic        say_ena;
   logic [31:0] say_meth;
   logic [31:0] say_v;
   logic [2:0]  count;
   logic [1:0]  err_count;

   int errors = 0;
   int checks = 0;

   logic [95:0] mq[$];
   logic [63:0] exp_q[$];
   int          m_err = 0;
   bit          m_ready = 1'b0;

   echo_request_input #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
      .CLK              (clk),
      .nRST             (n_rst),
      .pipe_enq_ena     (enq_ena),
      .pipe_enq_v       (enq_word),
      .pipe_enq_rdy     (enq_rdy),
      .request_say_ena  (say_ena),
      .request_say_meth (say_meth),
      .request_say_v    (say_v),
      .request_say_rdy  (say_rdy),
      .count            (count),
      .err_count        (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_rdy();
      return m_ready && (mq.size() < DEPTH);
   endfunction

   function automatic bit model_say();
      if (mq.size() > 0) return (mq[0][31:0] == 32'd1) && say_rdy;
`ifdef ECHO_REQUEST_INPUT_BYPASS_EN
      return enq_ena && model_rdy() && (enq_word[31:0] == 32'd1) && say_rdy;
`else
      return 1'b0;
`endif
   endfunction

   function automatic void bump_err();
      if (m_err < ERR_MAX) m_err++;
   endfunction

   // Reference model: occupancy is the queue length, words leave from the front.
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mq.delete();
         exp_q.delete();
         m_err   = 0;
         m_ready = 1'b0;
      end else begin
         bit acc;
         bit store;
         acc   = enq_ena && model_rdy();
         store = acc;
         if (mq.size() > 0) begin
            if (mq[0][31:0] == 32'd1) begin
               if (say_rdy) void'(mq.pop_front());
            end else begin
               void'(mq.pop_front());
               bump_err();
            end
         end
`ifdef ECHO_REQUEST_INPUT_BYPASS_EN
         else if (acc) begin
            if (enq_word[31:0] != 32'd1) begin
               bump_err();
               store = 1'b0;
            end else if (say_rdy) begin
               store = 1'b0;
            end
         end
`endif
         if (store) mq.push_back(enq_word);
         m_ready = 1'b1;
      end
   end

   // Monitor: state checks every cycle, say payloads popped from the scoreboard.
   always @(negedge clk) begin
      check("enq_rdy", 64'(enq_rdy), 64'(model_rdy()));
      check("count", 64'(count), 64'(mq.size()));
      check("err_count", 64'(err_count), 64'(m_err));
      check("say_ena", 64'(say_ena), 64'(model_say()));
      if (say_ena === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL say_unexpected: got meth=%0h v=%0h expected none at %0t",
                     say_meth, say_v, $time);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("say_payload", {say_meth, say_v}, e);
         end
      end
   end

   task automatic drive(input bit ena, input logic [95:0] word, input bit rdy);
      @(posedge clk);
      #1;
      enq_ena  = ena;
      enq_word = word;
      say_rdy  = rdy;
      if (ena && model_rdy() && word[31:0] == 32'd1)
         exp_q.push_back({word[63:32], word[95:64]});
   endtask

   function automatic logic [95:0] mk(input logic [31:0] v, input logic [31:0] meth,
                                      input logic [31:0] tag);
      return {v, meth, tag};
   endfunction

   task automatic do_reset();
      @(posedge clk);
      #1;
      enq_ena = 1'b0;
      n_rst   = 1'b0;
      #1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_rdy", 64'(enq_rdy), 64'd0);
      check("rst_say", 64'(say_ena), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   initial begin
      n_rst    = 1'b0;
      enq_ena  = 1'b0;
      enq_word = '0;
      say_rdy  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
      repeat (2) drive(1'b0, '0, 1'b1);

      // Single word.
      drive(1'b1, mk(32'h5, 32'hA, 32'd1), 1'b1);
      repeat (2) drive(1'b0, '0, 1'b1);

      // Backpressure: fill, one ignored word, then drain in order.
      for (int i = 0; i < 5; i++) drive(1'b1, mk(32'h100 + i, 32'h10 + i, 32'd1), 1'b0);
      drive(1'b0, '0, 1'b0);
      repeat (6) drive(1'b0, '0, 1'b1);

      // Mixed tags.
      drive(1'b1, mk(32'h21, 32'd1, 32'd1), 1'b1);
      drive(1'b1, mk(32'h22, 32'd2, 32'd7), 1'b1);
      drive(1'b1, mk(32'h23, 32'd3, 32'd1), 1'b1);
      repeat (3) drive(1'b0, '0, 1'b1);

      // Saturation of the 2-bit error counter.
      for (int i = 0; i < 5; i++) drive(1'b1, mk(32'h30 + i, 32'h40 + i, 32'h9 + i), 1'b1);
      repeat (3) drive(1'b0, '0, 1'b1);

      // Reset mid-stream with three words buffered.
      for (int i = 0; i < 3; i++) drive(1'b1, mk(32'h50 + i, 32'h60 + i, 32'd1), 1'b0);
      do_reset();
      repeat (3) drive(1'b0, '0, 1'b1);

      // Continuous traffic through wrapping pointers.
      for (int i = 0; i < 16; i++) drive(1'b1, mk(32'h700 + i, 32'h800 + i, 32'd1), 1'b1);
      repeat (2) drive(1'b0, '0, 1'b1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] tag;
         tag = ($urandom_range(0, 9) < 7) ? 32'd1 : $urandom;
         if (tag == 32'd1 && $urandom_range(0, 9) >= 7) tag = 32'd2;
         drive($urandom_range(0, 3) != 0, mk($urandom, $urandom, tag), $urandom_range(0, 3) != 0);
         if (i == 200) do_reset();
      end

      // Bounded drain.
      for (int i = 0; i < 20 && (mq.size() != 0 || exp_q.size() != 0); i++)
         drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);
      check("drain_pending", 64'(exp_q.size()), 64'd0);

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
